cpu_mem_axil_master: RTL and testbench
======================================

// Module: cpu_mem_axil_master
// PURPOSE
//  Bridge from the custom CPU's valid/ready memory port to a single AXI4-lite master, feeding s00 of the 1x2 AXI-lite interconnect.
//  Serialises CPU loads/stores into AXI-lite transactions, one outstanding at a time, and preserves program order.
//  Latches the first non-OKAY response in sticky error registers.
//  Keeps wrapping read/write transaction counters for the emu harness.
// PARAMETERS
//  DATA_WIDTH  32            data width of the CPU port and the AXI-lite port
//  ADDR_WIDTH  32            address width of the CPU port and the AXI-lite port
//  STRB_WIDTH  DATA_WIDTH/8  write-strobe width
//  AXI_PROT    3'b000        constant value driven on awprot and arprot
// PORTS
//  clk              in   1           single clock; all logic is rising-edge
//  rst              in   1           asynchronous, active-high reset
//  Address          in   ADDR_WIDTH  CPU request address
//  MemWrite         in   1           CPU store request valid
//  Write_data       in   DATA_WIDTH  store data
//  Write_strb       in   STRB_WIDTH  store byte enables
//  MemRead          in   1           CPU load request valid
//  Mem_Req_Ready    out  1           bridge accepts a request this cycle
//  Read_data        out  DATA_WIDTH  load data
//  Read_data_Valid  out  1           load data valid
//  Read_data_Ready  in   1           CPU accepts the load data
//  m_axil_*         AXI4-lite master: aw/w/b/ar/r channels (awaddr, awprot, awvalid, awready, wdata, wstrb, wvalid, wready,
//                   bresp, bvalid, bready, araddr, arprot, arvalid, arready, rdata, rresp, rvalid, rready)
//  err_valid        out  1           sticky: a non-OKAY response has been seen
//  err_addr         out  ADDR_WIDTH  address of the first errored transaction
//  err_is_write     out  1           1 = the first error came from a write
//  rd_count         out  32          count of completed reads; wraps
//  wr_count         out  32          count of completed writes; wraps
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE; every valid/ready output = 0 except Mem_Req_Ready.
//   - All data/addr registers, err_*, and counters = 0.
//   - Mem_Req_Ready = 1 once out of reset.
//   - Reset mid-transaction abandons it; the interconnect shares the same rst.
//  States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RD_HOLD.
//  Mem_Req_Ready = (state==IDLE), combinational.
//  IDLE:
//   - MemWrite=1: latch Address/Write_data/Write_strb -> WR_REQ.
//   - else MemRead=1: latch Address -> RD_REQ.
//   - Both asserted: write wins; the read is served on a later IDLE cycle (the CPU holds MemRead).
//  WR_REQ:
//   - awvalid and wvalid rise the cycle after acceptance and are tracked independently; each drops after its own handshake.
//   - When both handshakes are done, including in the same cycle -> WR_RESP.
//  WR_RESP: bready=1; on bvalid -> IDLE and wr_count++. Store latency with zero-wait slave: accept at T, aw/w handshake T+1, b at T+2, ready again at T+3.
//  RD_REQ: arvalid=1 until arready -> RD_RESP.
//  RD_RESP: rready=1; on rvalid register rdata into Read_data -> RD_HOLD and rd_count++.
//  RD_HOLD:
//   - Read_data_Valid=1 and Read_data stable until Read_data_Ready.
//   - Then -> IDLE; Read_data_Valid is 0 the next cycle.
//   - rready stays 0 in RD_HOLD.
//  All AXI outputs are registered. addr/data/strb stay stable while their valid is high (AXI rule).
//  Errors: bresp/rresp != 2'b00 sets err_valid, err_addr and err_is_write only if err_valid==0 (first error kept). Clear only on reset.
//   - Error read data is still returned to the CPU unchanged.
//  Counters: 32-bit, wrap from 0xFFFFFFFF to 0.
//  Address is passed through unaligned; no address decode is done here.
// TESTING
//  1. Store 0x1000 <- 0xDEADBEEF with strb 4'hF; zero-wait slave
//     -> aw/w handshake 1 cycle after accept, bready handshake next cycle.
//     -> Mem_Req_Ready back high 3 cycles after accept; wr_count=1.
//  2. Load 0x2004, slave rdata=0x12345678, Read_data_Ready held 0 for 4 cycles
//     -> Read_data_Valid=1 with stable data for 5 cycles, then drops; rd_count=1.
//  3. Slave takes awready 3 cycles before wready
//     -> awvalid drops after its handshake and wvalid stays high.
//     -> exactly one b handshake.
//  4. MemWrite and MemRead both high in one cycle
//     -> write transaction issued first, then AR for the same Address.
//  5. Load returns rresp=2'b10, then a store returns bresp=2'b11
//     -> err_valid=1, err_addr=load address, err_is_write=0 (second error ignored).
//  6. rst pulsed while arvalid=1
//     -> arvalid=0 asynchronously; after release Mem_Req_Ready=1, counters=0.

Source files
------------

// File: rtl/cpu_mem_axil_master.sv
// Bridge from the CPU valid/ready memory port to one AXI4-lite master.
// Ports: CPU req/load-data port, m_axil_* master, sticky err_*, rd/wr counters.
module cpu_mem_axil_master #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int          STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0]  AXI_PROT   = 3'b000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] Write_data,
  input  logic [STRB_WIDTH-1:0] Write_strb,
  input  logic                  MemRead,
  output logic                  Mem_Req_Ready,
  output logic [DATA_WIDTH-1:0] Read_data,
  output logic                  Read_data_Valid,
  input  logic                  Read_data_Ready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_is_write,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP,
    RD_REQ, RD_RESP, RD_HOLD
  } state_t;

  state_t state;
  logic   aw_ok;
  logic   w_ok;

  assign Mem_Req_Ready = (state == IDLE);
  assign m_axil_awprot = AXI_PROT;
  assign m_axil_arprot = AXI_PROT;

  // A channel is finished once its valid has dropped or
  // it handshakes this cycle; the two are tracked apart.
  assign aw_ok = !m_axil_awvalid || m_axil_awready;
  assign w_ok  = !m_axil_wvalid  || m_axil_wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      Read_data       <= '0;
      Read_data_Valid <= 1'b0;
      m_axil_awaddr   <= '0;
      m_axil_awvalid  <= 1'b0;
      m_axil_wdata    <= '0;
      m_axil_wstrb    <= '0;
      m_axil_wvalid   <= 1'b0;
      m_axil_bready   <= 1'b0;
      m_axil_araddr   <= '0;
      m_axil_arvalid  <= 1'b0;
      m_axil_rready   <= 1'b0;
      err_valid       <= 1'b0;
      err_addr        <= '0;
      err_is_write    <= 1'b0;
      rd_count        <= '0;
      wr_count        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (MemWrite) begin
            m_axil_awaddr  <= Address;
            m_axil_wdata   <= Write_data;
            m_axil_wstrb   <= Write_strb;
            m_axil_awvalid <= 1'b1;
            m_axil_wvalid  <= 1'b1;
            state          <= WR_REQ;
          end else if (MemRead) begin
            m_axil_araddr  <= Address;
            m_axil_arvalid <= 1'b1;
            state          <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (m_axil_awvalid && m_axil_awready)
            m_axil_awvalid <= 1'b0;
          if (m_axil_wvalid && m_axil_wready)
            m_axil_wvalid <= 1'b0;
          if (aw_ok && w_ok) begin
            m_axil_bready <= 1'b1;
            state         <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            wr_count      <= wr_count + 32'd1;
            if (m_axil_bresp != 2'b00 && !err_valid) begin
              err_valid    <= 1'b1;
              err_addr     <= m_axil_awaddr;
              err_is_write <= 1'b1;
            end
            state <= IDLE;
          end
        end
        RD_REQ: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m_axil_rvalid) begin
            Read_data       <= m_axil_rdata;
            Read_data_Valid <= 1'b1;
            m_axil_rready   <= 1'b0;
            rd_count        <= rd_count + 32'd1;
            if (m_axil_rresp != 2'b00 && !err_valid) begin
              err_valid    <= 1'b1;
              err_addr     <= m_axil_araddr;
              err_is_write <= 1'b0;
            end
            state <= RD_HOLD;
          end
        end
        RD_HOLD: begin
          if (Read_data_Ready) begin
            Read_data_Valid <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_axil_master.sv
// Directed bench for cpu_mem_axil_master with a small AXI-lite slave model.
// Covers store/load timing, split aw/w, write priority, sticky errors, reset.
module tb_cpu_mem_axil_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Address = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] Write_data = '0;
  logic [3:0]  Write_strb = '0;
  logic        MemRead = 1'b0;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready = 1'b0;
  logic [31:0] m_axil_awaddr;
  logic [2:0]  m_axil_awprot;
  logic        m_axil_awvalid;
  logic        m_axil_awready;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid;
  logic        m_axil_wready;
  logic [1:0]  m_axil_bresp;
  logic        m_axil_bvalid;
  logic        m_axil_bready;
  logic [31:0] m_axil_araddr;
  logic [2:0]  m_axil_arprot;
  logic        m_axil_arvalid;
  logic        m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid;
  logic        m_axil_rready;
  logic        err_valid;
  logic [31:0] err_addr;
  logic        err_is_write;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  int total = 0;
  int bad = 0;

  cpu_mem_axil_master dut (
    .clk(clk), .rst(rst),
    .Address(Address), .MemWrite(MemWrite),
    .Write_data(Write_data), .Write_strb(Write_strb),
    .MemRead(MemRead), .Mem_Req_Ready(Mem_Req_Ready),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
    .Read_data_Ready(Read_data_Ready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
    .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .err_valid(err_valid), .err_addr(err_addr),
    .err_is_write(err_is_write),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // slave knobs
  int          aw_lat = 0;
  int          w_lat = 0;
  logic        ar_block = 1'b0;
  logic [1:0]  bresp_val = 2'b00;
  logic [1:0]  rresp_val = 2'b00;
  logic [31:0] rdata_val = '0;

  // slave state and logs
  int          cyc = 0;
  int          aw_cnt = 0;
  int          w_cnt = 0;
  logic        aw_got = 1'b0;
  logic        w_got = 1'b0;
  int          aw_hs_n = 0;
  int          w_hs_n = 0;
  int          b_hs_n = 0;
  int          aw_cyc = 0;
  int          ar_cyc = 0;
  logic [31:0] ar_addr_seen = '0;
  logic [31:0] aw_addr_seen = '0;
  logic [31:0] w_data_seen = '0;

  assign m_axil_awready = m_axil_awvalid && (aw_cnt >= aw_lat);
  assign m_axil_wready  = m_axil_wvalid && (w_cnt >= w_lat);
  assign m_axil_arready = m_axil_arvalid && !ar_block;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0;
      w_cnt <= 0;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      m_axil_bvalid <= 1'b0;
      m_axil_bresp <= 2'b00;
      m_axil_rvalid <= 1'b0;
      m_axil_rdata <= '0;
      m_axil_rresp <= 2'b00;
    end else begin
      cyc <= cyc + 1;
      aw_cnt <= (m_axil_awvalid && !m_axil_awready) ? aw_cnt + 1 : 0;
      w_cnt <= (m_axil_wvalid && !m_axil_wready) ? w_cnt + 1 : 0;
      if (m_axil_awvalid && m_axil_awready) begin
        aw_got <= 1'b1;
        aw_hs_n <= aw_hs_n + 1;
        aw_cyc <= cyc;
        aw_addr_seen <= m_axil_awaddr;
      end
      if (m_axil_wvalid && m_axil_wready) begin
        w_got <= 1'b1;
        w_hs_n <= w_hs_n + 1;
        w_data_seen <= m_axil_wdata;
      end
      if ((aw_got || (m_axil_awvalid && m_axil_awready)) &&
          (w_got || (m_axil_wvalid && m_axil_wready))) begin
        m_axil_bvalid <= 1'b1;
        m_axil_bresp <= bresp_val;
        aw_got <= 1'b0;
        w_got <= 1'b0;
      end
      if (m_axil_bvalid && m_axil_bready) begin
        m_axil_bvalid <= 1'b0;
        b_hs_n <= b_hs_n + 1;
      end
      if (m_axil_arvalid && m_axil_arready) begin
        m_axil_rvalid <= 1'b1;
        m_axil_rdata <= rdata_val;
        m_axil_rresp <= rresp_val;
        ar_addr_seen <= m_axil_araddr;
        ar_cyc <= cyc;
      end
      if (m_axil_rvalid && m_axil_rready)
        m_axil_rvalid <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!Mem_Req_Ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({tag, "_tmo"}, 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    Address = a;
    Write_data = d;
    Write_strb = 4'hF;
    MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
    wait_idle("wr");
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    int n = 0;
    Address = a;
    MemRead = 1'b1;
    Read_data_Ready = 1'b1;
    @(negedge clk);
    MemRead = 1'b0;
    while (!Read_data_Valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rd_tmo", 32'd0, 32'd1);
    d = Read_data;
    @(negedge clk);
    Read_data_Ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          b0;

    // reset state
    #2;
    chk("rst_awvalid", {31'd0, m_axil_awvalid}, 32'd0);
    chk("rst_arvalid", {31'd0, m_axil_arvalid}, 32'd0);
    chk("rst_rdv", {31'd0, Read_data_Valid}, 32'd0);
    chk("rst_ready", {31'd0, Mem_Req_Ready}, 32'd1);
    chk("rst_wrcnt", wr_count, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: zero-wait store
    Address = 32'h1000;
    Write_data = 32'hDEADBEEF;
    Write_strb = 4'hF;
    MemWrite = 1'b1;
    chk("t1_ready0", {31'd0, Mem_Req_Ready}, 32'd1);
    @(negedge clk);
    MemWrite = 1'b0;
    chk("t1_awvalid", {31'd0, m_axil_awvalid}, 32'd1);
    chk("t1_wvalid", {31'd0, m_axil_wvalid}, 32'd1);
    chk("t1_awaddr", m_axil_awaddr, 32'h1000);
    chk("t1_wdata", m_axil_wdata, 32'hDEADBEEF);
    chk("t1_wstrb", {28'd0, m_axil_wstrb}, 32'hF);
    chk("t1_awready", {31'd0, m_axil_awready}, 32'd1);
    chk("t1_busy1", {31'd0, Mem_Req_Ready}, 32'd0);
    @(negedge clk);
    chk("t1_bready", {31'd0, m_axil_bready}, 32'd1);
    chk("t1_bvalid", {31'd0, m_axil_bvalid}, 32'd1);
    chk("t1_aw_drop", {31'd0, m_axil_awvalid}, 32'd0);
    chk("t1_busy2", {31'd0, Mem_Req_Ready}, 32'd0);
    @(negedge clk);
    chk("t1_ready3", {31'd0, Mem_Req_Ready}, 32'd1);
    chk("t1_wrcnt", wr_count, 32'd1);
    chk("t1_bhs", b_hs_n, 32'd1);
    chk("t1_bready0", {31'd0, m_axil_bready}, 32'd0);

    // 2: load with CPU back-pressure
    Address = 32'h2004;
    rdata_val = 32'h12345678;
    MemRead = 1'b1;
    Read_data_Ready = 1'b0;
    @(negedge clk);
    MemRead = 1'b0;
    chk("t2_arvalid", {31'd0, m_axil_arvalid}, 32'd1);
    chk("t2_araddr", m_axil_araddr, 32'h2004);
    @(negedge clk);
    chk("t2_rready", {31'd0, m_axil_rready}, 32'd1);
    chk("t2_arv_drop", {31'd0, m_axil_arvalid}, 32'd0);
    @(negedge clk);
    chk("t2_rd_cnt", rd_count, 32'd1);
    chk("t2_rready0", {31'd0, m_axil_rready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) Read_data_Ready = 1'b1;
      chk("t2_hold_v", {31'd0, Read_data_Valid}, 32'd1);
      chk("t2_hold_d", Read_data, 32'h12345678);
      @(negedge clk);
    end
    Read_data_Ready = 1'b0;
    chk("t2_v_drop", {31'd0, Read_data_Valid}, 32'd0);
    chk("t2_idle", {31'd0, Mem_Req_Ready}, 32'd1);

    // 3: awready three cycles ahead of wready
    aw_lat = 0;
    w_lat = 3;
    b0 = b_hs_n;
    Address = 32'h3000;
    Write_data = 32'hA5A5_0003;
    MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
    @(negedge clk);
    chk("t3_aw_drop", {31'd0, m_axil_awvalid}, 32'd0);
    chk("t3_w_held", {31'd0, m_axil_wvalid}, 32'd1);
    chk("t3_wdata", m_axil_wdata, 32'hA5A5_0003);
    @(negedge clk);
    chk("t3_w_held2", {31'd0, m_axil_wvalid}, 32'd1);
    wait_idle("t3");
    chk("t3_one_b", b_hs_n - b0, 32'd1);
    chk("t3_wdata_seen", w_data_seen, 32'hA5A5_0003);
    chk("t3_wrcnt", wr_count, 32'd2);
    w_lat = 0;

    // 4: write and read together, write first
    Address = 32'h4008;
    Write_data = 32'h0000_4444;
    rdata_val = 32'hCAFE_0004;
    MemWrite = 1'b1;
    MemRead = 1'b1;
    Read_data_Ready = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
    chk("t4_aw_first", {31'd0, m_axil_awvalid}, 32'd1);
    chk("t4_no_ar", {31'd0, m_axil_arvalid}, 32'd0);
    begin
      int n = 0;
      while (!m_axil_arvalid && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) chk("t4_ar_tmo", 32'd0, 32'd1);
    end
    MemRead = 1'b0;
    begin
      int n = 0;
      while (!Read_data_Valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) chk("t4_rd_tmo", 32'd0, 32'd1);
    end
    chk("t4_data", Read_data, 32'hCAFE_0004);
    @(negedge clk);
    Read_data_Ready = 1'b0;
    chk("t4_araddr", ar_addr_seen, 32'h4008);
    chk("t4_awaddr", aw_addr_seen, 32'h4008);
    chk("t4_order", {31'd0, aw_cyc < ar_cyc}, 32'd1);
    chk("t4_wrcnt", wr_count, 32'd3);
    chk("t4_rdcnt", rd_count, 32'd2);

    // 5: sticky first error
    chk("t5_noerr", {31'd0, err_valid}, 32'd0);
    rresp_val = 2'b10;
    rdata_val = 32'h0BAD_0005;
    do_read(32'h5010, rd);
    rresp_val = 2'b00;
    chk("t5_rdata", rd, 32'h0BAD_0005);
    chk("t5_err_v", {31'd0, err_valid}, 32'd1);
    chk("t5_err_a", err_addr, 32'h5010);
    chk("t5_err_w", {31'd0, err_is_write}, 32'd0);
    bresp_val = 2'b11;
    do_write(32'h6000, 32'h6666_6666);
    bresp_val = 2'b00;
    chk("t5_err_a2", err_addr, 32'h5010);
    chk("t5_err_w2", {31'd0, err_is_write}, 32'd0);
    chk("t5_wrcnt", wr_count, 32'd4);

    // 6: async reset while arvalid is high
    ar_block = 1'b1;
    Address = 32'h7000;
    MemRead = 1'b1;
    @(negedge clk);
    MemRead = 1'b0;
    chk("t6_arvalid", {31'd0, m_axil_arvalid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_ar_async", {31'd0, m_axil_arvalid}, 32'd0);
    chk("t6_cnt_async", rd_count, 32'd0);
    ar_block = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ready", {31'd0, Mem_Req_Ready}, 32'd1);
    chk("t6_rdcnt", rd_count, 32'd0);
    chk("t6_wrcnt", wr_count, 32'd0);
    chk("t6_err", {31'd0, err_valid}, 32'd0);
    chk("t6_errad", err_addr, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
